// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for an NxN systolic MAC array: lane j of each operand is
// delayed by j beats, and each pass is closed with N-1 zero flush beats and a done pulse.
module systolic_skew_feeder #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [N-1:0][DW-1:0] a_in,
  input  logic [N-1:0][DW-1:0] b_in,
  output logic                 in_ready,
  output logic [N-1:0][DW-1:0] a_skew,
  output logic [N-1:0][DW-1:0] b_skew,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] FEED_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'((N > 1) ? (N - 2) : 0);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          advance;
  logic          clear;
  logic          feed_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FEED;
      FEED:  if (in_valid && cnt == FEED_LAST) state_nxt = (N == 1) ? DONE : FLUSH;
      FLUSH: if (cnt == FLUSH_LAST) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control decoded from the current state
  always_comb begin
    advance   = 1'b0;
    clear     = 1'b0;
    feed_last = 1'b0;
    advance   = (state == FEED && in_valid) || (state == FLUSH);
    clear     = (state == IDLE) && start;
    feed_last = (state == FEED) && in_valid && (cnt == FEED_LAST);
  end

  // Beat counter: counts accepted beats in FEED, then flush beats in FLUSH
  always_ff @(posedge clk) begin
    if (rst || clear)                 cnt <= '0;
    else if (state == FEED) begin
      if (in_valid) cnt <= feed_last ? '0 : cnt + CW'(1);
    end
    else if (state == FLUSH)          cnt <= cnt + CW'(1);
    else                              cnt <= '0;
  end

  // Registered status outputs, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == FEED);
      busy      <= (state_nxt != IDLE);
      out_valid <= advance;
      done      <= (state == DONE);
    end
  end

  // Per-lane delay lines; lane j holds j stages ahead of its output register
  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [DW-1:0] a_x, b_x;
    logic [DW-1:0] a_q, b_q;

    assign a_x = (state == FEED) ? a_in[j] : '0;
    assign b_x = (state == FEED) ? b_in[j] : '0;
    assign a_skew[j] = a_q;
    assign b_skew[j] = b_q;

    if (j == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_x;
          b_q <= b_x;
        end
      end
    end else begin : g_delay
      logic [j-1:0][DW-1:0] a_d, b_d;

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          a_d <= '0;
          b_d <= '0;
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d[j-1];
          b_q <= b_d[j-1];
          for (int k = j - 1; k > 0; k--) begin
            a_d[k] <= a_d[k-1];
            b_d[k] <= b_d[k-1];
          end
          a_d[0] <= a_x;
          b_d[0] <= b_x;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: an N=3 instance for the skew, stall,
// reset and pass-sequencing scenarios, plus an N=1 instance for the degenerate case.
module tb_systolic_skew_feeder;

  logic clk;
  logic rst;

  logic            start, in_valid;
  logic [2:0][7:0] a_in, b_in;
  logic            in_ready, out_valid, busy, done;
  logic [2:0][7:0] a_skew, b_skew;

  logic            n1_start, n1_in_valid;
  logic [0:0][7:0] n1_a_in, n1_b_in;
  logic            n1_in_ready, n1_out_valid, n1_busy, n1_done;
  logic [0:0][7:0] n1_a_skew, n1_b_skew;

  int n_cmp = 0;
  int n_mis = 0;

  // Hand-computed A skew for A rows (1,2,3),(4,5,6),(7,8,9): [output beat][lane]
  int exp_tbl [5][3] = '{'{1, 0, 0}, '{4, 2, 0}, '{7, 5, 3}, '{0, 8, 6}, '{0, 0, 9}};

  logic [7:0] obs_a [8][3];
  logic [7:0] obs_b [8][3];
  int         nbeats, ndone, stall_bad, stall_seen;
  logic       ov_at_done;

  systolic_skew_feeder #(.N(3), .DW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .in_ready(in_ready),
    .a_skew(a_skew), .b_skew(b_skew), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  systolic_skew_feeder #(.N(1), .DW(8)) dut_n1 (
    .clk(clk), .rst(rst), .start(n1_start), .in_valid(n1_in_valid),
    .a_in(n1_a_in), .b_in(n1_b_in), .in_ready(n1_in_ready),
    .a_skew(n1_a_skew), .b_skew(n1_b_skew), .out_valid(n1_out_valid),
    .busy(n1_busy), .done(n1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_val(input int t, input int j, input int base, input bit isb);
    int v;
    v = exp_tbl[t][j];
    return (v == 0) ? 0 : v + base + (isb ? 10 : 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one N=3 pass and records what the DUT emits; comparisons live in the tests
  task automatic run_pass(input int base, input int stall_len, input bit poke);
    int  sent, gap;
    bit  rdy, in_stall;
    logic [2:0][7:0] prev_a, prev_b;
    nbeats = 0; ndone = 0; stall_bad = 0; stall_seen = 0; ov_at_done = 1'b1;
    sent = 0; gap = 0;
    start = 1'b1;
    tick();
    start = poke;
    for (int cyc = 0; cyc < 60 && ndone == 0; cyc++) begin
      in_stall = (stall_len > 0) && (sent == 1) && (gap < stall_len);
      if (sent < 3 && !in_stall) begin
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
          a_in[j] = 8'(base + 3 * sent + j + 1);
          b_in[j] = 8'(base + 3 * sent + j + 11);
        end
      end else begin
        in_valid = 1'b0;
        a_in = {3{8'hEE}};
        b_in = {3{8'hEE}};
        if (in_stall) gap++;
      end
      rdy    = in_ready;
      prev_a = a_skew;
      prev_b = b_skew;
      tick();
      if (in_valid && rdy) sent++;
      if (in_stall) begin
        stall_seen++;
        if (out_valid !== 1'b0 || a_skew !== prev_a || b_skew !== prev_b) stall_bad++;
      end
      if (out_valid === 1'b1) begin
        if (nbeats < 8) begin
          for (int j = 0; j < 3; j++) begin
            obs_a[nbeats][j] = a_skew[j];
            obs_b[nbeats][j] = b_skew[j];
          end
        end
        nbeats++;
      end
      if (done === 1'b1) begin
        ndone++;
        ov_at_done = out_valid;
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (a_skew !== '0 || b_skew !== '0) begin n_mis++; $display("FAIL reset_skew got a=%h b=%h want 0", a_skew, b_skew); end
    n_cmp++; if ({out_valid, in_ready, busy, done} !== 4'b0) begin n_mis++; $display("FAIL reset_flags got %b want 0000", {out_valid, in_ready, busy, done}); end
    n_cmp++; if ({n1_out_valid, n1_in_ready, n1_busy, n1_done} !== 4'b0) begin n_mis++; $display("FAIL reset_n1_flags got %b want 0000", {n1_out_valid, n1_in_ready, n1_busy, n1_done}); end
    rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; a_in = {8'd43, 8'd42, 8'd41}; b_in = {8'd53, 8'd52, 8'd51};
    tick(); tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_mis++; $display("FAIL midfeed_active got ov=%b busy=%b want 1 1", out_valid, busy); end
    rst = 1'b1; tick(); tick();
    n_cmp++; if (a_skew !== '0 || b_skew !== '0) begin n_mis++; $display("FAIL abort_skew got a=%h b=%h want 0", a_skew, b_skew); end
    n_cmp++; if ({out_valid, in_ready, busy, done} !== 4'b0) begin n_mis++; $display("FAIL abort_flags got %b want 0000", {out_valid, in_ready, busy, done}); end
    rst = 1'b0;
    run_pass(0, 0, 1'b0);
    n_cmp++; if (nbeats !== 5 || ndone !== 1) begin n_mis++; $display("FAIL reset_clean_pass got beats=%0d dones=%0d want 5 1", nbeats, ndone); end
    for (int t = 0; t < 5; t++)
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (obs_a[t][j] !== 8'(exp_val(t, j, 0, 0)) || obs_b[t][j] !== 8'(exp_val(t, j, 0, 1))) begin
          n_mis++; $display("FAIL reset_clean beat%0d lane%0d got a=%0d b=%0d want %0d %0d", t, j, obs_a[t][j], obs_b[t][j], exp_val(t, j, 0, 0), exp_val(t, j, 0, 1));
        end
      end
    tick();
  endtask

  task automatic test_basic();
    run_pass(0, 0, 1'b0);
    n_cmp++; if (nbeats !== 5) begin n_mis++; $display("FAIL basic_beats got %0d want 5", nbeats); end
    n_cmp++; if (ndone !== 1) begin n_mis++; $display("FAIL basic_done got %0d want 1", ndone); end
    n_cmp++; if (ov_at_done !== 1'b0) begin n_mis++; $display("FAIL basic_ov_at_done got %b want 0", ov_at_done); end
    for (int t = 0; t < 5; t++)
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (obs_a[t][j] !== 8'(exp_val(t, j, 0, 0)) || obs_b[t][j] !== 8'(exp_val(t, j, 0, 1))) begin
          n_mis++; $display("FAIL basic beat%0d lane%0d got a=%0d b=%0d want %0d %0d", t, j, obs_a[t][j], obs_b[t][j], exp_val(t, j, 0, 0), exp_val(t, j, 0, 1));
        end
      end
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_mis++; $display("FAIL basic_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_stall();
    run_pass(0, 2, 1'b0);
    n_cmp++; if (stall_seen !== 2 || stall_bad !== 0) begin n_mis++; $display("FAIL stall_hold got seen=%0d bad=%0d want 2 0", stall_seen, stall_bad); end
    n_cmp++; if (nbeats !== 5 || ndone !== 1) begin n_mis++; $display("FAIL stall_pass got beats=%0d dones=%0d want 5 1", nbeats, ndone); end
    for (int t = 0; t < 5; t++)
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (obs_a[t][j] !== 8'(exp_val(t, j, 0, 0)) || obs_b[t][j] !== 8'(exp_val(t, j, 0, 1))) begin
          n_mis++; $display("FAIL stall beat%0d lane%0d got a=%0d b=%0d want %0d %0d", t, j, obs_a[t][j], obs_b[t][j], exp_val(t, j, 0, 0), exp_val(t, j, 0, 1));
        end
      end
    tick();
  endtask

  task automatic test_start_ignored();
    int extra;
    run_pass(0, 0, 1'b1);
    n_cmp++; if (nbeats !== 5 || ndone !== 1) begin n_mis++; $display("FAIL poke_pass got beats=%0d dones=%0d want 5 1", nbeats, ndone); end
    for (int t = 0; t < 5; t++)
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (obs_a[t][j] !== 8'(exp_val(t, j, 0, 0))) begin
          n_mis++; $display("FAIL poke beat%0d lane%0d got a=%0d want %0d", t, j, obs_a[t][j], exp_val(t, j, 0, 0));
        end
      end
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1 || out_valid === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_mis++; $display("FAIL poke_quiet got %0d active cycles want 0", extra); end
  endtask

  task automatic test_n1();
    n1_start = 1'b1; tick(); n1_start = 1'b0;
    n_cmp++; if (n1_in_ready !== 1'b1) begin n_mis++; $display("FAIL n1_ready got %b want 1", n1_in_ready); end
    n1_in_valid = 1'b1; n1_a_in[0] = 8'd5; n1_b_in[0] = 8'd9;
    tick();
    n1_in_valid = 1'b0; n1_a_in[0] = 8'hEE; n1_b_in[0] = 8'hEE;
    n_cmp++; if (n1_out_valid !== 1'b1 || n1_a_skew[0] !== 8'd5 || n1_b_skew[0] !== 8'd9) begin
      n_mis++; $display("FAIL n1_beat got ov=%b a=%0d b=%0d want 1 5 9", n1_out_valid, n1_a_skew[0], n1_b_skew[0]);
    end
    n_cmp++; if (n1_done !== 1'b0 || n1_in_ready !== 1'b0) begin n_mis++; $display("FAIL n1_no_flush got done=%b rdy=%b want 0 0", n1_done, n1_in_ready); end
    tick();
    n_cmp++; if (n1_done !== 1'b1 || n1_out_valid !== 1'b0) begin n_mis++; $display("FAIL n1_done got done=%b ov=%b want 1 0", n1_done, n1_out_valid); end
    tick();
    n_cmp++; if (n1_done !== 1'b0 || n1_busy !== 1'b0) begin n_mis++; $display("FAIL n1_idle got done=%b busy=%b want 0 0", n1_done, n1_busy); end
  endtask

  task automatic test_back_to_back();
    run_pass(0, 0, 1'b0);
    n_cmp++; if (ndone !== 1) begin n_mis++; $display("FAIL b2b_first_done got %0d want 1", ndone); end
    tick();
    run_pass(20, 0, 1'b0);
    n_cmp++; if (nbeats !== 5 || ndone !== 1) begin n_mis++; $display("FAIL b2b_second got beats=%0d dones=%0d want 5 1", nbeats, ndone); end
    for (int t = 0; t < 5; t++)
      for (int j = 0; j < 3; j++) begin
        n_cmp++; if (obs_a[t][j] !== 8'(exp_val(t, j, 20, 0)) || obs_b[t][j] !== 8'(exp_val(t, j, 20, 1))) begin
          n_mis++; $display("FAIL b2b beat%0d lane%0d got a=%0d b=%0d want %0d %0d", t, j, obs_a[t][j], obs_b[t][j], exp_val(t, j, 20, 0), exp_val(t, j, 20, 1));
        end
      end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
    n1_start = 1'b0; n1_in_valid = 1'b0; n1_a_in = '0; n1_b_in = '0;
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_n1();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
